// File: rtl/fu_wb_pkg.sv
// Shared types and sizing for the FU writeback / CDB path.
// Holds the slot entry layout used by the arbiter and its clients.
package fu_wb_pkg;

  localparam int FU_COUNT     = 4;
  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int DATA_BITS    = 64;
  localparam int FU_IDX_BITS  = $clog2(FU_COUNT);

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                 inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]  data;
    logic [MAX_OPERANDS-1:0]                 data_valid;
  } wb_entry_t;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(
    input logic [FU_COUNT-1:0] v
  );
    return |(v & (v - FU_COUNT'(1)));
  endfunction

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// FU result handshake and CDB broadcast bundle.
// slave = arbiter side, master = FU / consumer side.
interface wb_cdb_arbiter_if;
  import fu_wb_pkg::*;

  logic [FU_COUNT-1:0]                   fu_in_valid;
  logic [FU_COUNT-1:0]                   fu_in_ready;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_in_inst_id;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_in_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] fu_in_data;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] fu_in_data_valid;

  logic                                  cdb_valid;
  logic [FU_IDX_BITS-1:0]                cdb_fu_index;
  logic [INST_ID_BITS-1:0]               cdb_inst_id;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  cdb_prn;
  logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] cdb_data;
  logic [MAX_OPERANDS-1:0]               cdb_data_valid;

  modport slave (
    input  fu_in_valid, fu_in_inst_id, fu_in_prn,
    input  fu_in_data, fu_in_data_valid,
    output fu_in_ready,
    output cdb_valid, cdb_fu_index, cdb_inst_id,
    output cdb_prn, cdb_data, cdb_data_valid
  );

  modport master (
    output fu_in_valid, fu_in_inst_id, fu_in_prn,
    output fu_in_data, fu_in_data_valid,
    input  fu_in_ready,
    input  cdb_valid, cdb_fu_index, cdb_inst_id,
    input  cdb_prn, cdb_data, cdb_data_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit at ptr, ptr+1, ... mod N.
// Purely combinational; caller owns the pointer register.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the pointer, stop at the first requester.
  always_comb begin
    logic found;
    int   j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// One-entry result slot per FU, round-robin onto a registered CDB.
// Also counts cycles where more than one slot competes.
module wb_cdb_arbiter
  import fu_wb_pkg::*;
#(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  wb_cdb_arbiter_if.slave     bus,
  output logic [CNT_BITS-1:0] conflict_count
);

  wb_entry_t              slot_q [FU_COUNT];
  wb_entry_t              in_ent [FU_COUNT];
  logic [FU_COUNT-1:0]    slot_valid_q, slot_valid_d;
  logic [FU_COUNT-1:0]    grant, accept, ready;
  logic [FU_IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [FU_IDX_BITS-1:0] win_idx;
  logic                   fire;

  wb_entry_t              cdb_q, cdb_d;
  logic                   cdb_valid_q, cdb_valid_d;
  logic [FU_IDX_BITS-1:0] cdb_idx_q, cdb_idx_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  rr_arbiter #(
    .N  (FU_COUNT),
    .IW (FU_IDX_BITS)
  ) u_arb (
    .req_i   (slot_valid_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  // Gather the FU-side fields into slot entries.
  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      in_ent[i].inst_id    = bus.fu_in_inst_id[i];
      in_ent[i].prn        = bus.fu_in_prn[i];
      in_ent[i].data       = bus.fu_in_data[i];
      in_ent[i].data_valid = bus.fu_in_data_valid[i];
    end
  end

  assign ready = {FU_COUNT{~flush}} & (~slot_valid_q | grant);
  assign accept = bus.fu_in_valid & ready;
  assign fire = (|grant) && !flush;
  assign bus.fu_in_ready = ready;

  // Next state for slots, pointer, CDB beat and conflict counter.
  always_comb begin
    slot_valid_d = (slot_valid_q & ~grant) | accept;
    if (flush) slot_valid_d = '0;

    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      if (win_idx == FU_IDX_BITS'(FU_COUNT - 1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = win_idx + FU_IDX_BITS'(1);
    end

    cdb_valid_d        = fire;
    cdb_d              = cdb_q;
    cdb_d.data_valid   = '0;
    cdb_idx_d          = cdb_idx_q;
    if (fire) begin
      cdb_d     = slot_q[win_idx];
      cdb_idx_d = win_idx;
    end

    cnt_d = cnt_q;
    if (multi_hot(slot_valid_q) && (cnt_q != '1))
      cnt_d = cnt_q + CNT_BITS'(1);
  end

  // Slot payloads load on accept; contents of empty slots are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FU_COUNT; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < FU_COUNT; i++)
        if (accept[i]) slot_q[i] <= in_ent[i];
    end
  end

  // Control state, CDB output register and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_q        <= '0;
      cdb_idx_q    <= '0;
      cnt_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
      cdb_idx_q    <= cdb_idx_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.cdb_valid      = cdb_valid_q;
  assign bus.cdb_fu_index   = cdb_idx_q;
  assign bus.cdb_inst_id    = cdb_q.inst_id;
  assign bus.cdb_prn        = cdb_q.prn;
  assign bus.cdb_data       = cdb_q.data;
  assign bus.cdb_data_valid = cdb_q.data_valid;
  assign conflict_count     = cnt_q;

endmodule

// File: doc/wb_cdb_arbiter.md
Name: wb_cdb_arbiter

Overview:
Shares the single common data bus (CDB) writeback path between FU_COUNT functional-unit/issue-queue pairs. Each FU hands its completed result (inst_id, output PRNs, data) into a one-entry holding slot. A round-robin arbiter then picks one slot per cycle and drives it onto a registered CDB output. The CDB output feeds PRF writes, ROB completion and the set_prn/set_prn_ready wakeup broadcast to every issue queue.

Parameters:
FU_COUNT, 4, number of requesting functional units
INST_ID_BITS, 6, ROB instruction id width
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, result slots per instruction
CNT_BITS, 32, width of the conflict performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash; drops all held and in-flight results
fu_in_valid[FU_COUNT]  in  1  FU result present
fu_in_ready[FU_COUNT]  out  1  slot can accept this cycle
fu_in_inst_id[FU_COUNT]  in  INST_ID_BITS  result instruction id
fu_in_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS  destination PRNs
fu_in_data[FU_COUNT][MAX_OPERANDS]  in  64  result data
fu_in_data_valid[FU_COUNT][MAX_OPERANDS]  in  1  per-operand write enable
cdb_valid  out  1  CDB carries a result this cycle
cdb_fu_index  out  $clog2(FU_COUNT)  source FU of the CDB result
cdb_inst_id  out  INST_ID_BITS  instruction id
cdb_prn[MAX_OPERANDS]  out  PRN_BITS  destination PRNs
cdb_data[MAX_OPERANDS]  out  64  data
cdb_data_valid[MAX_OPERANDS]  out  1  per-operand valid; forced 0 when cdb_valid=0
conflict_count  out  CNT_BITS  saturating count of cycles with more than one slot valid

Behaviour:
- Reset (rst=0, async):
  - all slots empty; rr_ptr=0; conflict_count=0.
  - cdb_valid=0 and cdb_data_valid all 0; cdb_fu_index, cdb_inst_id, cdb_prn, cdb_data all 0.
  - fu_in_ready all 1 after release.
- Slot i state: slot_valid[i] plus the captured fields.
- Grant (combinational from slot_valid and rr_ptr only, never from fu_in_valid): the first valid slot scanning rr_ptr, rr_ptr+1, ... modulo FU_COUNT. At most one grant per cycle.
- fu_in_ready[i] = !flush && (!slot_valid[i] || grant[i]). No combinational path from fu_in_valid to fu_in_ready.
- Accept when fu_in_valid[i] && fu_in_ready[i]: the slot loads the fields next edge. A simultaneous grant and accept on the same slot is a replace: slot stays valid with the new entry.
- Granted slot:
  - contents are registered into the cdb_* outputs next edge, with cdb_valid=1 for exactly one cycle;
  - the slot clears unless refilled;
  - rr_ptr <= (winner+1) mod FU_COUNT.
- No grant: cdb_valid=0 next cycle, cdb_data_valid all 0, other cdb fields hold; rr_ptr holds.
- Latency: accept at edge N, grant in cycle N+1, cdb_valid in cycle N+2. Throughput is 1 result per cycle aggregate and 1 per FU per cycle when uncontended.
- The CDB has no backpressure; consumers must take each cdb_valid cycle.
- Fairness: with all FU_COUNT slots continuously valid, each FU is granted exactly once every FU_COUNT cycles.
- flush=1:
  - all slot_valid clear at the edge;
  - no accept that cycle;
  - cdb_valid=0 next cycle, including any grant made in the flush cycle;
  - rr_ptr and conflict_count unaffected.
- conflict_count increments when popcount(slot_valid) >= 2; saturates at all-ones (no wrap).
- Reset asserted mid-operation discards all slots immediately; no partial CDB beat is emitted.
- Data fields of empty slots are don't-care. Only cdb_data_valid gates PRF writes.

Decomposition:
- Shared package fu_wb_pkg:
  - typedef wb_entry_t (inst_id, prn[MAX_OPERANDS], data[MAX_OPERANDS], data_valid[MAX_OPERANDS]);
  - localparam FU_IDX_BITS = $clog2(FU_COUNT).
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr, outputs one-hot grant and index. It is reusable for the dispatch router.
- Slots, output register and counter stay in wb_cdb_arbiter.

Test Plan:
- Single result: FU2 drives inst_id=5, prn={7,0,0}, data={0xDEAD,0,0}, data_valid={1,0,0} for one cycle. Expect cdb_valid only in cycle N+2, with cdb_fu_index=2, cdb_inst_id=5, cdb_prn[0]=7, cdb_data[0]=0xDEAD, cdb_data_valid={1,0,0}.
- Contention: all 4 FUs present results in the same cycle from reset (rr_ptr=0). Expect CDB order FU0,1,2,3 on consecutive cycles; conflict_count=3; fu_in_ready[3] low for 3 cycles.
- Back-to-back: FU1 holds fu_in_valid high with ids 1,2,3 while no other FU requests. Expect fu_in_ready[1] stays 1 and the CDB shows ids 1,2,3 on consecutive cycles.
- Fairness: all FUs assert valid continuously for 40 cycles. Expect each FU granted exactly 10 times, grant gap always 4; conflict_count saturates correctly when CNT_BITS=4 (stops at 15).
- Flush: fill 3 slots, then assert flush for one cycle. Expect cdb_valid=0 the following cycle, no dropped ids ever appear, fu_in_ready low during flush and high after.
- Async reset: assert rst low mid-burst between clock edges. Expect cdb_valid=0 and all fu_in_ready=1 immediately after release, and rr_ptr restarts at FU0.
